encoder_quad_rx: RTL and testbench
==================================

# encoder_quad_rx

Front-end for the taxi wheel encoder. Samples the raw quadrature A/B lines, synchronises and glitch-filters them, and decodes direction and steps. Accumulates forward steps and emits one single-cycle `encoder_pulses` strobe per fixed distance unit to the fare counter. Counting is gated by the trip-launch flag, and illegal quadrature jumps are reported through a sticky error flag.

## Interface
- `FILT_LEN`, default 4: consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates (legal range 1..15).
- `CNT_PER_UNIT`, default 16'd400: net forward quadrature steps per distance unit (legal range 1..65535).
- `sys_clk`  in  1  system clock; the block's only clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `enc_a`  in  1  raw encoder channel A, asynchronous to `sys_clk`.
- `enc_b`  in  1  raw encoder channel B, asynchronous to `sys_clk`.
- `flag_key_launch`  in  1  trip running; 1 enables distance accumulation.
- `encoder_pulses`  out  1  one-cycle high strobe per completed distance unit.
- `dir`  out  1  direction of the last legal step: 1 = forward, 0 = reverse.
- `err_flag`  out  1  sticky; set on an illegal quadrature transition.
- `unit_cnt`  out  16  distance units emitted since launch; saturates at 16'hFFFF.

## Operation
- Synchroniser: two flops per channel; the second stage is the synchronised value.
- Filter, per channel:
  - A 4-bit counter increments while the synchronised value differs from the filtered value, and clears when they are equal.
  - When the counter reaches FILT_LEN, the filtered value takes the synchronised value and the counter clears.
- Decoder: holds the previous filtered pair `{A,B}`.
  - Forward sequence: 00→10→11→01→00.
  - Reverse sequence: 00→01→11→10→00.
  - Each cycle, the current pair is compared with the previous pair:
    - Equal: no step.
    - Forward neighbour: forward step, `dir`<=1.
    - Reverse neighbour: reverse step, `dir`<=0.
    - Both bits changed: illegal. No step, `dir` holds, and `err_flag`<=1 when `flag_key_launch`=1.
  - The previous pair always updates, including on an illegal transition, and it tracks regardless of `flag_key_launch`. Enabling counting therefore never produces a spurious step.
- Accumulator `acc`, 16 bits, range 0..CNT_PER_UNIT-1. It is only active when `flag_key_launch`=1.
  - Forward step with `acc`==CNT_PER_UNIT-1: `acc`<=0, `encoder_pulses`<=1, and `unit_cnt`<=`unit_cnt`+1 unless it is already 16'hFFFF.
  - Forward step otherwise: `acc`+1.
  - Reverse step: `acc`-1 if `acc`>0, else hold at 0. Reverse motion never removes emitted units.
- `flag_key_launch`=0: `acc`, `unit_cnt` and `err_flag` clear to 0 and `encoder_pulses` stays 0. This takes priority over a step in the same cycle.
- CNT_PER_UNIT=1: every forward step produces a strobe.

## Timing
- Reset values: `encoder_pulses`=0, `dir`=1, `err_flag`=0, `unit_cnt`=0.
- Internal state at reset: `acc`=0, filter counters 0, synchroniser flops, filtered values and previous pair all 0.
- Reset asserted mid-operation returns everything to the reset values asynchronously. No strobe is issued on reset release.
- Latency: `encoder_pulses`, `dir`, `err_flag` and `unit_cnt` update on the (FILT_LEN+3)th `sys_clk` rising edge after the first edge that samples the new input level.
  - The count is 2 synchroniser edges, plus FILT_LEN filter edges, plus 1 decode edge.
- `encoder_pulses` is registered and exactly one cycle wide. Two strobes are separated by at least CNT_PER_UNIT×(FILT_LEN+1) cycles.
- Input pulses shorter than FILT_LEN cycles are rejected.
- Maximum trackable rate is one channel transition per FILT_LEN+1 cycles. Faster input may surface as an illegal transition.
- A launch falling edge and a completing forward step in the same cycle: clear wins, no strobe.
- `unit_cnt` at 16'hFFFF: strobes continue, the count holds.

## Test plan
- Reset, then launch=1, FILT_LEN=4, CNT_PER_UNIT=4. Drive 8 forward steps spaced 10 cycles apart:
  - Exactly 2 one-cycle strobes.
  - Each strobe occurs 7 cycles after the 4th and 8th input transitions.
  - `unit_cnt`=2 and `dir`=1.
- Launch=1, CNT_PER_UNIT=4. Drive 3 forward, then 2 reverse, then 3 forward steps:
  - `dir` goes to 0 during the reverse steps.
  - A single strobe on the final forward step (`acc` 3→1→4).
  - `unit_cnt`=1.
- A 3-cycle glitch on `enc_a` with FILT_LEN=4, followed by a legal step:
  - The glitch produces no step.
  - The legal step is counted normally and `err_flag` stays 0.
- Change `enc_a` and `enc_b` simultaneously (00→11) with launch=1:
  - `err_flag`=1 and stays 1.
  - No strobe and no `acc` change.
  - Dropping launch to 0 clears `err_flag`.
- Launch=0 with 20 forward steps, then launch=1 with 4 steps (CNT_PER_UNIT=4):
  - No strobe while launch=0.
  - One strobe after the 4th step.
- Assert `sys_rst_n`=0 mid-count (`acc`=3, `unit_cnt`=5):
  - Outputs return to their reset values immediately.
  - After release, 4 forward steps give exactly one strobe and `unit_cnt`=1.

Source files
------------

// File: rtl/encoder_quad_rx_if.sv
// rtl/encoder_quad_rx_if.sv - encoder front-end signal bundle (raw A/B, launch gate, decoded outputs)
interface encoder_quad_rx_if;
  logic        enc_a;
  logic        enc_b;
  logic        flag_key_launch;
  logic        encoder_pulses;
  logic        dir;
  logic        err_flag;
  logic [15:0] unit_cnt;

  // Driver side: the encoder wiring and trip controller.
  modport master (
    output enc_a,
    output enc_b,
    output flag_key_launch,
    input  encoder_pulses,
    input  dir,
    input  err_flag,
    input  unit_cnt
  );

  // Decoder side.
  modport slave (
    input  enc_a,
    input  enc_b,
    input  flag_key_launch,
    output encoder_pulses,
    output dir,
    output err_flag,
    output unit_cnt
  );
endinterface

// File: rtl/encoder_quad_rx.sv
// rtl/encoder_quad_rx.sv - quadrature sync/filter/decode front-end emitting one strobe per distance unit
module encoder_quad_rx #(
  parameter int unsigned FILT_LEN     = 4,
  parameter logic [15:0] CNT_PER_UNIT = 16'd400
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  encoder_quad_rx_if.slave   bus
);

  // Pair bit 1 is channel A, bit 0 is channel B throughout.
  localparam logic [3:0]  FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic [15:0] ACC_LAST  = CNT_PER_UNIT - 16'd1;

  logic [1:0]  sync1_q;
  logic [1:0]  sync2_q;
  logic [3:0]  filt_cnt_q [2];
  logic [1:0]  filt_q;
  logic [1:0]  prev_q;
  logic [15:0] acc_q;
  logic        pulse_q;
  logic        dir_q;
  logic        err_q;
  logic [15:0] unit_q;

  logic        step_fwd;
  logic        step_rev;
  logic        step_bad;

  // Two-flop synchroniser for both raw channels.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {bus.enc_a, bus.enc_b};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel glitch filter: a new level must persist FILT_LEN cycles before it is accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      filt_cnt_q[0] <= 4'd0;
      filt_cnt_q[1] <= 4'd0;
      filt_q        <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2_q[ch] == filt_q[ch]) begin
          filt_cnt_q[ch] <= 4'd0;
        end else if (filt_cnt_q[ch] == FILT_LAST) begin
          filt_q[ch]     <= sync2_q[ch];
          filt_cnt_q[ch] <= 4'd0;
        end else begin
          filt_cnt_q[ch] <= filt_cnt_q[ch] + 4'd1;
        end
      end
    end
  end

  // Classify the filtered pair against last cycle's pair (forward order 00-10-11-01).
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_bad = 1'b0;
    case ({prev_q, filt_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
      default: ;
    endcase
  end

  // Previous pair tracks unconditionally so enabling launch never yields a phantom step.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_q <= 2'b00;
    end else begin
      prev_q <= filt_q;
    end
  end

  // Direction follows every legal step; illegal jumps leave it untouched.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dir_q <= 1'b1;
    end else if (step_fwd) begin
      dir_q <= 1'b1;
    end else if (step_rev) begin
      dir_q <= 1'b0;
    end
  end

  // Distance accumulation, unit strobe, saturating unit count and sticky error, all gated by launch.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q   <= 16'd0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
      unit_q  <= 16'd0;
    end else begin
      pulse_q <= 1'b0;
      if (!bus.flag_key_launch) begin
        acc_q  <= 16'd0;
        err_q  <= 1'b0;
        unit_q <= 16'd0;
      end else begin
        if (step_bad) begin
          err_q <= 1'b1;
        end
        if (step_fwd) begin
          if (acc_q == ACC_LAST) begin
            acc_q   <= 16'd0;
            pulse_q <= 1'b1;
            if (unit_q != 16'hFFFF) begin
              unit_q <= unit_q + 16'd1;
            end
          end else begin
            acc_q <= acc_q + 16'd1;
          end
        end else if (step_rev) begin
          if (acc_q != 16'd0) begin
            acc_q <= acc_q - 16'd1;
          end
        end
      end
    end
  end

  assign bus.encoder_pulses = pulse_q;
  assign bus.dir            = dir_q;
  assign bus.err_flag       = err_q;
  assign bus.unit_cnt       = unit_q;

endmodule

// File: tb/tb_encoder_quad_rx.sv
// tb/tb_encoder_quad_rx.sv - randomized and directed bench for encoder_quad_rx against a step-level model
module tb_encoder_quad_rx;

  localparam int LAT = 7;
  localparam int CPU = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  encoder_quad_rx_if bus();

  encoder_quad_rx #(.FILT_LEN(4), .CNT_PER_UNIT(16'd4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model of the wheel and the fare-side view of it.
  logic [1:0] seq [4];
  int pos = 0;
  int m_acc = 0;
  int m_units = 0;
  int m_dir = 1;
  int m_err = 0;
  int m_launch = 0;
  int exp_strobes = 0;
  int exp_strobe_cyc = -1;
  int strobe_cnt = 0;
  logic prev_pulse = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe monitor: width and arrival cycle of every strobe.
  always @(negedge sys_clk) begin
    if (bus.encoder_pulses) begin
      strobe_cnt++;
      chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
      chk("strobe_cycle", cyc, exp_strobe_cyc);
    end
    prev_pulse = bus.encoder_pulses;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_pos();
    bus.enc_a = seq[pos][1];
    bus.enc_b = seq[pos][0];
  endtask

  task automatic step(input bit fwd, input int gap);
    pos = fwd ? (pos + 1) % 4 : (pos + 3) % 4;
    drive_pos();
    m_dir = fwd ? 1 : 0;
    if (m_launch != 0) begin
      if (fwd) begin
        m_acc++;
        if (m_acc == CPU) begin
          m_acc = 0;
          exp_strobes++;
          exp_strobe_cyc = cyc + LAT;
          if (m_units < 65535) m_units++;
        end
      end else if (m_acc > 0) begin
        m_acc--;
      end
    end
    wait_cyc(gap);
  endtask

  task automatic set_launch(input int v);
    bus.flag_key_launch = v[0];
    m_launch = v;
    if (v == 0) begin
      m_acc = 0;
      m_units = 0;
      m_err = 0;
    end
    wait_cyc(2);
  endtask

  task automatic quiet_check(input string tag);
    wait_cyc(10);
    chk({tag, "_units"}, {16'd0, bus.unit_cnt}, m_units);
    chk({tag, "_err"}, {31'd0, bus.err_flag}, m_err);
    chk({tag, "_dir"}, {31'd0, bus.dir}, m_dir);
    chk({tag, "_strobes"}, strobe_cnt, exp_strobes);
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    sys_rst_n = 1'b0;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.flag_key_launch = 1'b0;
    wait_cyc(3);
    chk("rst_pulse", {31'd0, bus.encoder_pulses}, 0);
    chk("rst_dir", {31'd0, bus.dir}, 1);
    chk("rst_err", {31'd0, bus.err_flag}, 0);
    chk("rst_units", {16'd0, bus.unit_cnt}, 0);
    sys_rst_n = 1'b1;
    wait_cyc(3);

    // 8 forward steps: two strobes at input+7 cycles.
    set_launch(1);
    for (int i = 0; i < 8; i++) step(1'b1, 10);
    quiet_check("fwd8");

    // 3 forward, 2 reverse, 3 forward: one strobe.
    set_launch(0);
    set_launch(1);
    for (int i = 0; i < 3; i++) step(1'b1, 10);
    for (int i = 0; i < 2; i++) step(1'b0, 10);
    chk("rev_dir", {31'd0, bus.dir}, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 10);
    quiet_check("mixed");

    // 3-cycle glitch on A is rejected, then a legal step counts.
    bus.enc_a = ~bus.enc_a;
    wait_cyc(3);
    drive_pos();
    wait_cyc(12);
    quiet_check("glitch");
    step(1'b1, 10);
    quiet_check("after_glitch");

    // Illegal double change sets sticky error without moving acc.
    pos = (pos + 2) % 4;
    drive_pos();
    m_err = 1;
    wait_cyc(12);
    quiet_check("illegal");
    wait_cyc(20);
    chk("err_sticky", {31'd0, bus.err_flag}, 1);
    set_launch(0);
    quiet_check("err_clear");

    // Steps while launch is low are ignored; then 4 steps give one strobe.
    for (int i = 0; i < 20; i++) step(1'b1, 8);
    quiet_check("launch_off");
    set_launch(1);
    for (int i = 0; i < 4; i++) step(1'b1, 10);
    quiet_check("launch_on");

    // Reach acc=3, units=5, then asynchronous reset.
    set_launch(0);
    set_launch(1);
    for (int i = 0; i < 23; i++) step(1'b1, 7);
    quiet_check("pre_reset");
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_units", {16'd0, bus.unit_cnt}, 0);
    chk("async_rst_dir", {31'd0, bus.dir}, 1);
    chk("async_rst_pulse", {31'd0, bus.encoder_pulses}, 0);
    pos = 0;
    drive_pos();
    m_acc = 0; m_units = 0; m_dir = 1; m_err = 0;
    wait_cyc(3);
    sys_rst_n = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < 4; i++) step(1'b1, 10);
    quiet_check("post_reset");

    // Randomized walk with occasional launch toggles.
    for (int blk = 0; blk < 8; blk++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_launch(0);
        set_launch(1);
      end
      for (int i = 0; i < 25; i++) begin
        step($urandom_range(0, 9) < 7, $urandom_range(6, 12));
      end
      quiet_check("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
